nfc_ram_arb: RTL and testbench

NFC_RAM_ARB -- requirements
Module: nfc_ram_arb

---
 rtl/nfc_ram_arb_pkg.sv | 30 +++
 rtl/nfc_ram_arb.sv | 160 ++++++++++++++++
 tb/tb_nfc_ram_arb.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/nfc_ram_arb_pkg.sv
// Shared parameters and types for the NFC / host SRAM arbiter.
//   RAM_AW / RAM_DW : SRAM address and data widths
//   arb_state_e     : arbiter FSM encoding (IDLE=00, PEND=01, RDAT=10)
//   host_buf_t      : latched host request
package nfc_ram_arb_pkg;

  localparam int unsigned RAM_AW = 13;
  localparam int unsigned RAM_DW = 16;
  localparam int unsigned RAM_BW = 2;
  localparam int unsigned STAT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PEND = 2'b01,
    ST_RDAT = 2'b10
  } arb_state_e;

  typedef struct packed {
    logic              wr;
    logic [RAM_AW-1:0] addr;
    logic [RAM_BW-1:0] be;
    logic [RAM_DW-1:0] wdata;
  } host_buf_t;

  // Saturating increment for the wait statistics counter.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/nfc_ram_arb.sv
// Arbitrates one single-port SRAM between the NFC datapath and a host port.
// The NFC always wins and sees zero added latency; the host request is
// buffered and issued in the first cycle the NFC leaves the SRAM free.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   nfc_ram_*             NFC access (cen/wen active-low), ram_nfc_dout
//   host_req/wr/addr/be/wdata, host_ack, host_rdata   host request port
//   sram_*                SRAM macro (sram_dout valid 1 cycle after cen low)
//   stat_clr, host_wait_max   worst-case host wait statistic
//
// Optional feature: define NFC_RAM_ARB_STAT_EN to build the wait counter;
// otherwise host_wait_max is tied to zero and stat_clr is ignored.
module nfc_ram_arb
  import nfc_ram_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  // NFC side
  input  logic [RAM_AW-1:0] nfc_ram_addr,
  input  logic              nfc_ram_cen,
  input  logic [RAM_BW-1:0] nfc_ram_wen,
  input  logic [RAM_DW-1:0] nfc_ram_din,
  output logic [RAM_DW-1:0] ram_nfc_dout,
  // Host side
  input  logic              host_req,
  input  logic              host_wr,
  input  logic [RAM_AW-1:0] host_addr,
  input  logic [RAM_BW-1:0] host_be,
  input  logic [RAM_DW-1:0] host_wdata,
  output logic              host_ack,
  output logic [RAM_DW-1:0] host_rdata,
  // SRAM side
  output logic [RAM_AW-1:0] sram_addr,
  output logic              sram_cen,
  output logic [RAM_BW-1:0] sram_wen,
  output logic [RAM_DW-1:0] sram_din,
  input  logic [RAM_DW-1:0] sram_dout,
  // Status
  input  logic              stat_clr,
  output logic [STAT_W-1:0] host_wait_max
);

  arb_state_e        state_q, state_d;
  host_buf_t         buf_q, buf_d;
  logic              host_ack_q, host_ack_d;
  logic [RAM_DW-1:0] host_rdata_q, host_rdata_d;
  logic              host_issue_c;

  // Read data goes straight back to the NFC regardless of who owns the SRAM.
  assign ram_nfc_dout = sram_dout;
  assign host_ack     = host_ack_q;
  assign host_rdata   = host_rdata_q;

  // State and host-side registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      buf_q        <= '0;
      host_ack_q   <= 1'b0;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      host_ack_q   <= host_ack_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  // Next-state logic and SRAM port mux.
  always_comb begin
    state_d      = state_q;
    buf_d        = buf_q;
    host_ack_d   = 1'b0;
    host_rdata_d = host_rdata_q;
    host_issue_c = 1'b0;
    sram_addr    = nfc_ram_addr;
    sram_din     = nfc_ram_din;
    sram_cen     = 1'b1;
    sram_wen     = '1;

    if (!nfc_ram_cen) begin
      sram_cen = 1'b0;
      sram_wen = nfc_ram_wen;
    end

    unique case (state_q)
      ST_IDLE: begin
        // host_req is still held high in the ack cycle; that is not a new request.
        if (host_req && !host_ack_q) begin
          buf_d.wr    = host_wr;
          buf_d.addr  = host_addr;
          buf_d.be    = host_be;
          buf_d.wdata = host_wdata;
          state_d     = ST_PEND;
        end
      end
      ST_PEND: begin
        if (nfc_ram_cen) begin
          host_issue_c = 1'b1;
          sram_addr    = buf_q.addr;
          sram_din     = buf_q.wdata;
          sram_cen     = 1'b0;
          sram_wen     = buf_q.wr ? ~buf_q.be : '1;
          if (buf_q.wr) begin
            host_ack_d = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            state_d    = ST_RDAT;
          end
        end
      end
      ST_RDAT: begin
        host_rdata_d = sram_dout;
        host_ack_d   = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef NFC_RAM_ARB_STAT_EN
  logic [STAT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [STAT_W-1:0] wait_max_q, wait_max_d;

  // Wait counter restarts on PEND entry; the value at issue is the number of
  // cycles the host was held off by the NFC.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    wait_max_d = wait_max_q;
    if (state_q == ST_IDLE && state_d == ST_PEND) begin
      wait_cnt_d = '0;
    end else if (state_q == ST_PEND) begin
      wait_cnt_d = sat_inc(wait_cnt_q);
    end
    if (stat_clr) begin
      wait_max_d = '0;
    end else if (host_issue_c && (wait_cnt_q > wait_max_q)) begin
      wait_max_d = wait_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
      wait_max_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      wait_max_q <= wait_max_d;
    end
  end

  assign host_wait_max = wait_max_q;
`else
  logic unused_stat;
  assign unused_stat   = stat_clr ^ host_issue_c;
  assign host_wait_max = '0;
`endif

endmodule

// File: tb/tb_nfc_ram_arb.sv
// Directed self-checking bench for nfc_ram_arb with a behavioural SRAM and
// a read-data scoreboard.
module tb_nfc_ram_arb;

  logic        clk;
  logic        rst_n;
  logic [12:0] nfc_ram_addr;
  logic        nfc_ram_cen;
  logic [1:0]  nfc_ram_wen;
  logic [15:0] nfc_ram_din;
  logic [15:0] ram_nfc_dout;
  logic        host_req;
  logic        host_wr;
  logic [12:0] host_addr;
  logic [1:0]  host_be;
  logic [15:0] host_wdata;
  logic        host_ack;
  logic [15:0] host_rdata;
  logic [12:0] sram_addr;
  logic        sram_cen;
  logic [1:0]  sram_wen;
  logic [15:0] sram_din;
  logic [15:0] sram_dout;
  logic        stat_clr;
  logic [7:0]  host_wait_max;

  int          n_checks = 0;
  int          n_err    = 0;
  logic [15:0] exp_q[$];
  int          wmax_model = 0;
  logic [15:0] mem [0:8191];

  nfc_ram_arb dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .nfc_ram_addr  (nfc_ram_addr),
    .nfc_ram_cen   (nfc_ram_cen),
    .nfc_ram_wen   (nfc_ram_wen),
    .nfc_ram_din   (nfc_ram_din),
    .ram_nfc_dout  (ram_nfc_dout),
    .host_req      (host_req),
    .host_wr       (host_wr),
    .host_addr     (host_addr),
    .host_be       (host_be),
    .host_wdata    (host_wdata),
    .host_ack      (host_ack),
    .host_rdata    (host_rdata),
    .sram_addr     (sram_addr),
    .sram_cen      (sram_cen),
    .sram_wen      (sram_wen),
    .sram_din      (sram_din),
    .sram_dout     (sram_dout),
    .stat_clr      (stat_clr),
    .host_wait_max (host_wait_max)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port SRAM: read data one cycle after cen low.
  always @(posedge clk) begin
    if (!sram_cen) begin
      sram_dout <= mem[sram_addr];
      if (!sram_wen[0]) mem[sram_addr][7:0]  <= sram_din[7:0];
      if (!sram_wen[1]) mem[sram_addr][15:8] <= sram_din[15:8];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_wmax(input string tag);
`ifdef NFC_RAM_ARB_STAT_EN
    check(tag, 32'(host_wait_max), 32'(wmax_model));
`else
    check(tag, 32'(host_wait_max), 32'h0);
`endif
  endtask

  task automatic nfc_idle();
    nfc_ram_cen  = 1'b1;
    nfc_ram_wen  = 2'b11;
    nfc_ram_addr = 13'h0AAA;
    nfc_ram_din  = 16'h5555;
  endtask

  // One host transfer. The NFC is busy in cycles 1..busy (cycle 0 = request
  // cycle) and optionally in the RDAT cycle; stat_clr can be pulsed at issue.
  task automatic host_xfer(input string tag, input logic wr, input logic [12:0] addr,
                           input logic [1:0] be, input logic [15:0] wdata,
                           input logic [15:0] exp_rd, input int busy,
                           input bit nfc_in_rdat, input bit clr_at_issue);
    int   cyc;
    int   issue_cyc;
    bit   got_ack;
    bit   nfc_busy;
    int   exp_lat;
    int   waited;
    logic [15:0] exp_pop;
    if (!wr) exp_q.push_back(exp_rd);
    exp_lat   = wr ? busy + 2 : busy + 3;
    issue_cyc = -1;
    got_ack   = 1'b0;
    cyc       = 0;
    @(posedge clk); #1;
    host_req   = 1'b1;
    host_wr    = wr;
    host_addr  = addr;
    host_be    = be;
    host_wdata = wdata;
    while (!got_ack && cyc < 400) begin
      nfc_busy = (cyc >= 1 && cyc <= busy) || (nfc_in_rdat && cyc == busy + 2);
      if (nfc_busy) begin
        nfc_ram_cen  = 1'b0;
        nfc_ram_wen  = 2'b11;
        nfc_ram_addr = 13'h1000 + 13'(cyc);
      end else begin
        nfc_idle();
      end
      stat_clr = clr_at_issue && (cyc == busy + 1);
      @(negedge clk);
      if (nfc_busy) begin
        check({tag, "_nfc_follow"}, {15'h0, sram_cen, sram_wen, sram_addr},
              {15'h0, 1'b0, 2'b11, nfc_ram_addr});
      end else if (!sram_cen && issue_cyc < 0) begin
        issue_cyc = cyc;
        check({tag, "_issue"}, {1'b0, sram_wen, sram_addr, wr ? sram_din : 16'h0},
              {1'b0, wr ? ~be : 2'b11, addr, wr ? wdata : 16'h0});
        waited = (busy > 255) ? 255 : busy;
        if (clr_at_issue) wmax_model = 0;
        else if (waited > wmax_model) wmax_model = waited;
      end
      if (host_ack) begin
        got_ack = 1'b1;
      end else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    check({tag, "_ack_lat"}, got_ack ? 32'(cyc) : 32'd999, 32'(exp_lat));
    check({tag, "_issue_cyc"}, 32'(issue_cyc), 32'(busy + 1));
    if (!wr && exp_q.size() > 0) begin
      exp_pop = exp_q.pop_front();
      if (got_ack) check({tag, "_rdata"}, 32'(host_rdata), 32'(exp_pop));
    end
    if (got_ack) check_wmax({tag, "_wmax"});
    // host_req is still high at the ack-cycle edge; it must not start a new access.
    @(posedge clk); #1;
    host_req = 1'b0;
    stat_clr = 1'b0;
    nfc_idle();
    @(negedge clk);
    check({tag, "_post_ack"}, {30'h0, host_ack, sram_cen}, {30'h0, 1'b0, 1'b1});
  endtask

  initial begin
    rst_n      = 1'b1;
    host_req   = 1'b0;
    host_wr    = 1'b0;
    host_addr  = '0;
    host_be    = '0;
    host_wdata = '0;
    stat_clr   = 1'b0;
    nfc_idle();
    #1 rst_n = 1'b0;
    #2;
    check("rst_outputs", {7'h0, host_ack, host_rdata, host_wait_max}, 32'h0);
    check("rst_sram_idle", {15'h0, sram_cen, sram_wen, sram_addr},
          {15'h0, 1'b1, 2'b11, 13'h0AAA});
    check("rst_sram_din", 32'(sram_din), 32'h5555);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic write then read-back, NFC idle.
    host_xfer("wr_a55a", 1'b1, 13'h0010, 2'b11, 16'hA55A, 16'h0, 0, 1'b0, 1'b0);
    host_xfer("rd_a55a", 1'b0, 13'h0010, 2'b00, 16'h0, 16'hA55A, 0, 1'b1, 1'b0);

    // Host read held off by 10 NFC cycles.
    host_xfer("rd_wait10", 1'b0, 13'h0010, 2'b00, 16'h0, 16'hA55A, 10, 1'b0, 1'b0);

    // Byte-enable write.
    host_xfer("wr_ffff", 1'b1, 13'h0020, 2'b11, 16'hFFFF, 16'h0, 0, 1'b0, 1'b0);
    host_xfer("wr_be01", 1'b1, 13'h0020, 2'b01, 16'h1234, 16'h0, 0, 1'b0, 1'b0);
    host_xfer("rd_ff34", 1'b0, 13'h0020, 2'b00, 16'h0, 16'hFF34, 2, 1'b0, 1'b0);

    // NFC write pass-through, then NFC read-back and host read-back.
    @(posedge clk); #1;
    nfc_ram_cen  = 1'b0;
    nfc_ram_wen  = 2'b00;
    nfc_ram_addr = 13'h0030;
    nfc_ram_din  = 16'hBEEF;
    @(negedge clk);
    check("nfc_wr_pass", {sram_cen, sram_wen, sram_addr, sram_din},
          {1'b0, 2'b00, 13'h0030, 16'hBEEF});
    @(posedge clk); #1;
    nfc_ram_wen = 2'b11;
    @(posedge clk); #1;
    nfc_idle();
    @(negedge clk);
    check("nfc_rd_dout", 32'(ram_nfc_dout), 32'hBEEF);
    host_xfer("rd_beef", 1'b0, 13'h0030, 2'b00, 16'h0, 16'hBEEF, 0, 1'b0, 1'b0);

    // Reset while a host read is pending behind the NFC.
    @(posedge clk); #1;
    host_req  = 1'b1;
    host_wr   = 1'b0;
    host_addr = 13'h0010;
    @(posedge clk); #1;
    nfc_ram_cen  = 1'b0;
    nfc_ram_addr = 13'h0100;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_pend_out", {7'h0, host_ack, host_rdata, host_wait_max}, 32'h0);
    host_req = 1'b0;
    nfc_idle();
    wmax_model = 0;
    #1;
    check("rst_pend_sram", {31'h0, sram_cen}, 32'h1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_no_ack", {30'h0, host_ack, sram_cen}, {30'h0, 1'b0, 1'b1});
    end
    host_xfer("rd_after_rst", 1'b0, 13'h0010, 2'b00, 16'h0, 16'hA55A, 0, 1'b0, 1'b0);

    // Wait statistics: saturating wait with clear at issue, then a short wait.
    host_xfer("rd_wait3", 1'b0, 13'h0020, 2'b00, 16'h0, 16'hFF34, 3, 1'b0, 1'b0);
    host_xfer("rd_wait300_clr", 1'b0, 13'h0020, 2'b00, 16'h0, 16'hFF34, 300, 1'b0, 1'b1);
    host_xfer("rd_wait5", 1'b0, 13'h0010, 2'b00, 16'h0, 16'hA55A, 5, 1'b0, 1'b0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
